// File: rtl/audio_mixer.sv
// -----------------------------------------------------------------------------
// audio_mixer
//   Multi-channel one-shot square-wave sound engine. Each channel latches its
//   half-period and tone length on a rising trigger edge, then plays a square
//   wave (high hp cycles, low hp cycles, ...) for exactly len cycles. The
//   channel waves are combined by a selectable mixer into one 1-bit output.
//
// Parameters
//   NUM_CH  number of tone channels (1..8)
//   PW      half-period field width (clk cycles)
//   LW      tone-length field width (clk cycles)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   trigger      per-channel start request (rising edge starts/restarts)
//   half_period  per-channel half-period, channel i at [i*PW +: PW]
//   tone_length  per-channel length,      channel i at [i*LW +: LW]
//   mix_mode     00/11 = OR, 01 = priority (lowest index), 10 = sigma-delta
//   mute         forces sound low; channels keep running
//   busy         channel i is playing
//   sound        mixed 1-bit audio
// -----------------------------------------------------------------------------
module audio_mixer #(
   parameter int NUM_CH = 4,
   parameter int PW     = 12,
   parameter int LW     = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CH-1:0]    trigger,
   input  logic [NUM_CH*PW-1:0] half_period,
   input  logic [NUM_CH*LW-1:0] tone_length,
   input  logic [1:0]           mix_mode,
   input  logic                 mute,
   output logic [NUM_CH-1:0]    busy,
   output logic                 sound
);

   localparam int AW = $clog2(NUM_CH + 1);
   localparam logic [AW:0] N_T = (AW+1)'(NUM_CH);

   logic [NUM_CH-1:0] trig_q_reg;
   logic              armed_reg;
   logic [NUM_CH-1:0] busy_vec;
   logic [NUM_CH-1:0] wave_vec;

   logic              mix_reg;
   logic              sound_reg;
   logic [AW-1:0]     acc_reg;

   logic [NUM_CH-1:0] act;
   logic [AW-1:0]     s_cnt;
   logic [AW:0]       sd_t;
   logic              pri_wave;
   logic              mix_next;
   logic [AW-1:0]     acc_next;

   // Trigger history. armed_reg stays low for the first edge after reset so
   // that a trigger already held high across reset only loads the history
   // and never counts as a fresh rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_q_reg <= '0;
         armed_reg  <= 1'b0;
      end else begin
         trig_q_reg <= trigger;
         armed_reg  <= 1'b1;
      end
   end

   // Per-channel tone generators
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [PW-1:0] hp_reg;
         logic [PW-1:0] phase_reg;
         logic [LW-1:0] rem_reg;
         logic          busy_ch_reg;
         logic          wave_ch_reg;
         logic [PW-1:0] hp_in;
         logic [PW-1:0] hp_eff;
         logic [LW-1:0] len_in;
         logic          start;

         assign hp_in  = half_period[gi*PW +: PW];
         assign len_in = tone_length[gi*LW +: LW];
         // a zero half-period would never toggle; treat it as one cycle
         assign hp_eff = (hp_in == '0) ? PW'(1) : hp_in;
         assign start  = armed_reg & trigger[gi] & ~trig_q_reg[gi] & (len_in != '0);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hp_reg      <= '0;
               phase_reg   <= '0;
               rem_reg     <= '0;
               busy_ch_reg <= 1'b0;
               wave_ch_reg <= 1'b0;
            end else if (start) begin
               // start (or restart) has priority over a natural end
               hp_reg      <= hp_eff;
               phase_reg   <= hp_eff - PW'(1);
               rem_reg     <= len_in - LW'(1);
               busy_ch_reg <= 1'b1;
               wave_ch_reg <= 1'b1;
            end else if (busy_ch_reg) begin
               if (rem_reg == '0) begin
                  busy_ch_reg <= 1'b0;
                  wave_ch_reg <= 1'b0;
               end else begin
                  rem_reg <= rem_reg - LW'(1);
                  if (phase_reg == '0) begin
                     wave_ch_reg <= ~wave_ch_reg;
                     phase_reg   <= hp_reg - PW'(1);
                  end else begin
                     phase_reg <= phase_reg - PW'(1);
                  end
               end
            end
         end

         assign busy_vec[gi] = busy_ch_reg;
         assign wave_vec[gi] = wave_ch_reg;
      end
   endgenerate

   // Mixer combinational logic
   always_comb begin
      act      = wave_vec & busy_vec;
      s_cnt    = '0;
      pri_wave = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         s_cnt = s_cnt + AW'(act[i]);
      end
      // scan from the top so the lowest busy index is the last one written
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (busy_vec[i]) begin
            pri_wave = wave_vec[i];
         end
      end
      sd_t     = {1'b0, acc_reg} + {1'b0, s_cnt};
      mix_next = 1'b0;
      acc_next = '0;
      case (mix_mode)
         2'b01: mix_next = pri_wave;
         2'b10: begin
            // first-order sigma-delta: output density = S / NUM_CH
            if (sd_t >= N_T) begin
               mix_next = 1'b1;
               acc_next = AW'(sd_t - N_T);
            end else begin
               mix_next = 1'b0;
               acc_next = AW'(sd_t);
            end
         end
         default: mix_next = |act;
      endcase
   end

   // Mix and output registers; accumulator is held at zero outside mode 10
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mix_reg   <= 1'b0;
         acc_reg   <= '0;
         sound_reg <= 1'b0;
      end else begin
         mix_reg   <= mix_next;
         acc_reg   <= acc_next;
         sound_reg <= mix_reg & ~mute;
      end
   end

   assign busy  = busy_vec;
   assign sound = sound_reg;

endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
Parametrised multi-channel sound engine that succeeds the fixed two-source jump/game-over audio path. Each of NUM_CH channels is a one-shot square-wave tone generator. Per-channel pitch and duration are runtime inputs, latched when the channel is triggered. Channel waves are combined by a selectable mixing mode (OR, fixed priority, or first-order sigma-delta density) into the single-bit sound pin driven to the buzzer/speaker.

Parameters:
NUM_CH, 4, number of tone channels (1..8)
PW, 12, width of each half-period field in clk cycles
LW, 20, width of each tone-length field in clk cycles

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trigger  input  NUM_CH  per-channel start request; rising edge starts or restarts the channel
half_period  input  NUM_CH*PW  per-channel half-period; channel i uses bits [i*PW +: PW]
tone_length  input  NUM_CH*LW  per-channel total duration in cycles; channel i uses bits [i*LW +: LW]
mix_mode  input  2  00=OR, 01=priority (lowest index wins), 10=sigma-delta, 11=OR
mute  input  1  forces sound low; channels keep running
busy  output  NUM_CH  channel i is currently playing
sound  output  1  mixed 1-bit audio

Behaviour:
- Reset values: rst_n low asynchronously clears all state.
  - busy=0, sound=0, all wave bits 0.
  - Trigger edge-detect history, phase/length counters and the sigma-delta accumulator all cleared.
  - Reset mid-tone aborts the tone. After release, a trigger input already held high does not start a channel; a fresh rising edge is required.
- Edge detect: trig_q registered each cycle. start_i = trigger[i] & ~trig_q[i].
- Start at edge k (start_i seen, tone_length_i != 0):
  - Latch hp_i = max(half_period_i, 1) and len_i = tone_length_i.
  - busy[i]=1, wave_i=1, phase_i=hp_i-1, remaining_i=len_i-1.
- Start with tone_length_i == 0 is ignored. A channel already busy keeps playing unchanged.
- While busy, each cycle:
  - If remaining_i == 0: busy[i]=0, wave_i=0.
  - Else remaining_i decrements, and
    - if phase_i == 0: wave_i toggles and phase_i reloads to hp_i-1;
    - else phase_i decrements.
- Result: wave_i is high hp cycles, then low hp cycles, repeating, for exactly len_i cycles total.
- Retrigger: a start_i while busy restarts the channel at that edge with freshly latched values. Wave goes high immediately, even if it was high.
- Simultaneous start and natural end on the same edge: start wins.
- Inputs half_period and tone_length may change freely while busy. Only latched copies are used.
- Mix stage (registered, edge k+1, from wave/busy registered at edge k):
  - OR mode: mix = |(wave & busy).
  - Priority mode: mix = wave of the lowest-index busy channel. mix=0 if none busy.
  - Sigma-delta mode: S = number of channels with wave&busy high (width clog2(NUM_CH+1)).
    - t = acc + S. If t >= NUM_CH: mix=1, acc = t - NUM_CH; else mix=0, acc = t.
    - acc width is clog2(NUM_CH+1); it never exceeds NUM_CH-1.
    - acc clears when mix_mode leaves 10.
- Output stage (edge k+2): sound = mix & ~mute.
- Total latency from trigger rising edge sampled at edge k to first sound high: edge k+2.
- mix_mode changes take effect at the next mix register update. No glitch filtering.
- busy is the registered channel state: it rises at edge k and falls at edge k+len.

Test Plan:
- Single tone: NUM_CH=4, OR mode, ch0 hp=2, len=8, trigger 0→1 sampled at edge 10 → busy[0] high edges 10..17, low at 18; sound high 12-13, low 14-15, high 16-17, low 18-19, 0 thereafter.
- Retrigger: ch0 hp=3, len=12, second rising edge at offset 5 → busy stays 1 with no gap; wave restarts high at offset 5; busy falls at offset 17; sound reflects the restarted pattern 2 cycles later.
- Priority vs OR: ch1 hp=1, ch2 hp=4, both started the same edge, mode 01 → sound follows ch1 (alternating every cycle); mode 00 → OR pattern 1111,1010-style per hp.
- Sigma-delta: NUM_CH=4, ch0 hp=ch1 hp=1000, both started together, mode 10 → during the first half-period, sound density exactly 2 of every 4 cycles (1 in 2); acc never ≥4.
- Zero length and mute: trigger ch3 with len=0 → busy[3] stays 0, sound 0. Then mute=1 during a ch0 tone → sound 0 while busy[0] still counts down on schedule.
- Reset mid-tone: assert rst_n low during ch0 tone with trigger held high → busy=0, sound=0 immediately; after release no restart until trigger drops and rises again.
